dds_freq_sweep: RTL
===================

Name: dds_freq_sweep

Overview:
Control stage directly upstream of the DDS phase accumulator. It generates the 32-bit frequency tuning word K and the 11-bit phase offset P that the accumulator registers each clock. It produces linear frequency sweeps (single, repeating, or triangle) from a start word to a stop word, with a programmable step size and a programmable dwell per step.

Parameters:
KW, 32, frequency-word width (matches the accumulator K input)
PW, 11, phase-offset width (matches the accumulator P input)
DW, 16, dwell counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a sweep when idle
abort  input  1  level/pulse; terminates sweep at next edge
mode  input  2  00 single, 01 repeat, 10 triangle, 11 treated as single
f_start  input  KW  sweep start word
f_stop  input  KW  sweep stop word
f_step  input  KW  step magnitude (unsigned)
dwell  input  DW  extra cycles held per step
phase_in  input  PW  requested phase offset
K  output  KW  frequency word to accumulator
P  output  PW  phase offset to accumulator
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at sweep completion
dir  output  1  0 = moving toward f_stop, 1 = moving back toward f_start (triangle mode)

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high. While rst is high: K=0, P=0, busy=0, done=0, dir=0, state IDLE, dwell counter 0.
- P is a registered copy of phase_in every cycle, independent of state (1-cycle latency).
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches f_start, f_stop, f_step, dwell, and mode into shadow registers.
  - Same edge: K<=f_start, busy<=1, dir<=0, dwell counter<=0, go to RUN.
  - Inputs are not sampled again until the next start.
- Sweep direction: up when f_stop >= f_start, otherwise down. Decided once at start.
- Step size: a latched f_step of 0 is treated as 1.
- RUN, dwell: each output value is held for dwell+1 cycles. Counter counts 0..dwell; the step occurs on the cycle the counter equals dwell, and the counter then returns to 0. dwell=0 means a step every cycle.
- RUN, step arithmetic: computed in KW+1 bits.
  - Next value = K +/- f_step, according to the current target.
  - If the result passes the target, or overflows/underflows, K is clamped to the target exactly.
- RUN, end-of-leg: when K already equals the target at a dwell expiry:
  - single: go to FINISH.
  - repeat: K<=f_start, continue RUN; no done pulse.
  - triangle: toggle dir, swap the target (f_stop <-> f_start), continue RUN. The turnaround value is held for one full dwell period; it is not repeated.
- f_start == f_stop: single mode holds f_start for dwell+1 cycles, then finishes. Repeat and triangle modes hold the value constant indefinitely.
- FINISH (one cycle): done=1, busy<=0, K remains at f_stop, then go to IDLE.
- K holds its last value in IDLE; it is not zeroed.
- abort:
  - Sampled in RUN and FINISH. Has priority over stepping: next edge goes to IDLE, busy<=0, no done pulse, K frozen at its current value.
  - abort and start together in IDLE: abort wins and start is ignored.
- start while busy=1 is ignored. Shadow registers are unchanged.
- Reset asserted mid-sweep forces reset values immediately (asynchronously). After release the block sits in IDLE awaiting start.
- Outputs K, busy, done, and dir are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst high mid-sweep (K=0x1000) -> K=0, P=0, busy=0, done=0, dir=0 with no clock edge; after release, stays IDLE until start.
- Single up sweep: f_start=100, f_stop=130, f_step=10, dwell=1, mode=00 -> K=100,100,110,110,120,120,130,130, then done pulses 1 cycle; busy falls with done; K holds 130.
- Clamp and down sweep: f_start=50, f_stop=20, f_step=12, dwell=0 -> K=50,38,26,20, then done; dir stays 0.
- Triangle: f_start=0, f_stop=3, f_step=1, dwell=0, mode=10 -> K=0,1,2,3,2,1,0,1...; dir toggles on leaving 3 and on leaving 0; done never pulses.
- Overflow and zero step: f_start=0xFFFFFFF0, f_stop=0xFFFFFFFF, f_step=0x20 -> second K=0xFFFFFFFF (clamped, no wrap). Separately, f_step=0 with f_start=5, f_stop=7 -> K=5,6,7.
- Abort and start interaction: start during RUN leaves the sweep unchanged. abort at K=110 -> busy=0 next cycle, K stays 110, no done. phase_in=0x3FF -> P=0x3FF one cycle later, in any state.

Source files
------------

// File: rtl/dds_freq_sweep_if.sv
// Control/data bundle between the sweep controller and its host.
// The slave side is the sweep controller; the master side drives the sweep requests.
interface dds_freq_sweep_if #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [KW-1:0] f_start;
  logic [KW-1:0] f_stop;
  logic [KW-1:0] f_step;
  logic [DW-1:0] dwell;
  logic [PW-1:0] phase_in;
  logic [KW-1:0] K;
  logic [PW-1:0] P;
  logic          busy;
  logic          done;
  logic          dir;

  modport master (
    output start, abort, mode, f_start, f_stop, f_step, dwell, phase_in,
    input  K, P, busy, done, dir
  );

  modport slave (
    input  start, abort, mode, f_start, f_stop, f_step, dwell, phase_in,
    output K, P, busy, done, dir
  );
endinterface

// File: rtl/dds_freq_sweep.sv
// Frequency-sweep controller feeding a DDS phase accumulator with tuning word K
// and phase offset P; supports single, repeating and triangle linear sweeps.
module dds_freq_sweep #(
  parameter int KW = 32,
  parameter int PW = 11,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dds_freq_sweep_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state;
  logic [KW-1:0] sh_start;
  logic [KW-1:0] sh_stop;
  logic [KW-1:0] sh_step;
  logic [DW-1:0] sh_dwell;
  logic [1:0]    sh_mode;
  logic          sh_up;
  logic [DW-1:0] cnt;

  logic [KW-1:0] k_p1;
  logic [PW-1:0] phase_p1;
  logic          busy_p1;
  logic          done_p1;
  logic          dir_p1;

  logic [KW-1:0] target;
  logic [KW-1:0] alt_target;
  logic          toward_up;
  logic          expire;
  logic          at_tgt;
  logic [KW-1:0] k_step;
  logic [KW-1:0] k_turn;

  // One step toward tgt in KW+1 bits; overshoot, carry-out or borrow saturates at tgt.
  function automatic logic [KW-1:0] step_clamp(input logic [KW-1:0] cur,
                                               input logic [KW-1:0] tgt,
                                               input logic [KW-1:0] stp,
                                               input logic          up);
    logic [KW:0] ext;
    if (up) begin
      ext = {1'b0, cur} + {1'b0, stp};
      if (ext[KW] || (ext[KW-1:0] > tgt)) return tgt;
    end else begin
      ext = {1'b0, cur} - {1'b0, stp};
      if (ext[KW] || (ext[KW-1:0] < tgt)) return tgt;
    end
    return ext[KW-1:0];
  endfunction

  // dir flips the leg: the target becomes the opposite end and the step sense inverts.
  assign target     = dir_p1 ? sh_start : sh_stop;
  assign alt_target = dir_p1 ? sh_stop  : sh_start;
  assign toward_up  = sh_up ^ dir_p1;
  assign expire     = (cnt == sh_dwell);
  assign at_tgt     = (k_p1 == target);
  assign k_step     = step_clamp(k_p1, target, sh_step, toward_up);
  assign k_turn     = step_clamp(k_p1, alt_target, sh_step, ~toward_up);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
      sh_mode  <= '0;
      sh_up    <= 1'b0;
      cnt      <= '0;
      k_p1     <= '0;
      phase_p1 <= '0;
      busy_p1  <= 1'b0;
      done_p1  <= 1'b0;
      dir_p1   <= 1'b0;
    end else begin
      phase_p1 <= bus.phase_in;
      done_p1  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            sh_start <= bus.f_start;
            sh_stop  <= bus.f_stop;
            sh_step  <= (bus.f_step == '0) ? KW'(1) : bus.f_step;
            sh_dwell <= bus.dwell;
            sh_mode  <= bus.mode;
            sh_up    <= (bus.f_stop >= bus.f_start);
            k_p1     <= bus.f_start;
            busy_p1  <= 1'b1;
            dir_p1   <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_p1 <= 1'b0;
            state   <= IDLE;
          end else if (expire) begin
            cnt <= '0;
            if (!at_tgt) begin
              k_p1 <= k_step;
            end else begin
              case (sh_mode)
                2'b01: k_p1 <= sh_start;
                2'b10: begin
                  // Turnaround steps straight off the end value so it is not held twice.
                  dir_p1 <= ~dir_p1;
                  k_p1   <= k_turn;
                end
                default: begin
                  done_p1 <= 1'b1;
                  busy_p1 <= 1'b0;
                  state   <= FINISH;
                end
              endcase
            end
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        FINISH: begin
          busy_p1 <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.K    = k_p1;
  assign bus.P    = phase_p1;
  assign bus.busy = busy_p1;
  assign bus.done = done_p1;
  assign bus.dir  = dir_p1;

endmodule
